alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width (legal range 4..32).
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), giving the width of the shift-amount field taken from b.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-005 The port en SHALL be an input, 1 bit wide: clock enable; when 0, all state (including in-flight operations) is frozen.
REQ-006 The port start SHALL be an input, 1 bit wide: an operation request, sampled when en=1.
REQ-007 The port op_code SHALL be an input, 4 bits wide: the operation select.
REQ-008 The ports a and b SHALL be inputs, WIDTH bits each: the operands.
REQ-009 The port c_in SHALL be an input, 1 bit wide: the carry-in for arithmetic ops.
REQ-010 The port y SHALL be an output, WIDTH bits wide: the registered result, held until the next completion.
REQ-011 The flag outputs c_out, zero, negative and overflow SHALL each be 1-bit registered outputs.
REQ-012 The port busy SHALL be an output, 1 bit wide: high while a multi-cycle operation is in progress.
REQ-013 The port done SHALL be an output, 1 bit wide: a single-cycle pulse marking the cycle in which y and the flags are updated.

Function
REQ-014 A request SHALL be accepted at a rising edge only when rst=0, en=1, start=1 and busy=0; a start while busy SHALL be ignored and not queued.
REQ-015 Operands SHALL be captured at acceptance; later changes to a, b, op_code and c_in SHALL NOT affect an in-flight operation.
REQ-016 Single-cycle ops SHALL update y and the flags, and assert done, at the acceptance edge.
- 0000: a+c_in
- 0001: a+b+c_in
- 0010: a+~b+c_in
- 0011: a-1+c_in
- 0100: a&b
- 0101: a|b
- 0110: a^b
- 0111: ~a
- 1000: clear to 0
- 1100: accumulate, y+a+c_in using the current y
- 1101..1111: y=0
REQ-017 For arithmetic ops (0000-0011, 1100), c_out SHALL be the carry out of bit WIDTH-1 of the WIDTH+1-bit sum.
REQ-018 For arithmetic ops, overflow SHALL be the two's-complement signed overflow of that sum, taking the second operand as 0, b, ~b, all-ones or y respectively.
REQ-019 For logic ops, clear and undefined ops, c_out and overflow SHALL be 0.
REQ-020 For all ops, zero SHALL be 1 iff the new y is 0, and negative SHALL be the new y[WIDTH-1].
REQ-021 For the multi-cycle ops 1001 (shift left logical by b[SHW-1:0]) and 1010 (shift right logical by b[SHW-1:0]), the shift SHALL proceed one bit per enabled cycle.
REQ-022 A shift amount of 0 SHALL complete at the acceptance edge with y=a and c_out=0.
REQ-023 A shift amount of n>0 SHALL set busy from the acceptance edge and complete n enabled cycles after acceptance.
REQ-024 For a shift, c_out SHALL be the last bit shifted out, and overflow SHALL be 0.
REQ-025 The multi-cycle op 1011 SHALL be an unsigned shift-add multiply, a*b, one partial product per enabled cycle, completing WIDTH enabled cycles after acceptance.
REQ-026 For a multiply, y SHALL be the low WIDTH bits of the product, c_out SHALL be 1 iff the high WIDTH bits are nonzero, and overflow SHALL equal c_out.
REQ-027 The state machine SHALL have states IDLE, SHIFT and MUL.
- IDLE->SHIFT on acceptance of 1001/1010 with n>0; IDLE->MUL on acceptance of 1011.
- SHIFT/MUL->IDLE at the completing edge.
- An internal down-counter of width SHW+1 SHALL count the remaining steps.
REQ-028 busy SHALL fall at the completing edge, the same edge that sets done; a new request SHALL be acceptable at the following edge.
REQ-029 y and the flags SHALL NOT change during SHIFT/MUL; intermediate values SHALL be kept in internal registers.
REQ-030 done SHALL be 0 in every cycle other than a completion cycle.
REQ-031 With en=0, done SHALL drop to 0 and the counter, state, y and flags SHALL hold.
REQ-032 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-033 With rst=1 at a rising edge, and regardless of en, the block SHALL load y=0, c_out=zero=negative=overflow=0, busy=0, done=0 and state=IDLE.
REQ-034 A reset mid-operation SHALL abort the operation with no done pulse.
REQ-035 rst SHALL take priority over start.

Verification (WIDTH=8)
REQ-036 The bench SHALL hold rst=1 for 2 cycles with start=1 and check y=0x00, all flags=0, busy=0 and done=0.
REQ-037 The bench SHALL issue op 0001, a=0x7F, b=0x00, c_in=1 and check y=0x80, negative=1, overflow=1, c_out=0, with done high for exactly 1 cycle.
REQ-038 The bench SHALL issue op 0010, a=0x05, b=0x05, c_in=1 and check y=0x00, zero=1, c_out=1, overflow=0.
REQ-039 The bench SHALL issue op 1011, a=13, b=11, then pulse start again on cycle 3.
- Check busy for 8 cycles, then y=0x8F, c_out=0.
- Check the second start is ignored.
- Check that holding en=0 for 2 mid-operation cycles delays done by exactly 2 cycles.
REQ-040 The bench SHALL issue op 1001, a=0x81, b=0x03 and check done 3 cycles after acceptance with y=0x08, c_out=0; op 1010 with a=0x81, b=0x01 SHALL give y=0x40, c_out=1.
REQ-041 The bench SHALL assert rst on the 4th cycle of a multiply and check busy=0 and y=0 next cycle, with no done; then op 1100 with a=0x10, c_in=0 issued twice SHALL give y=0x20.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle arithmetic/logic ops and
// multi-cycle bit-serial shifts and a shift-add unsigned multiply.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - clock enable; freezes all state when low
//   start, op_code  - request and operation select
//   a, b, c_in      - operands and carry-in
//   y               - registered result, held between completions
//   c_out, zero, negative, overflow - registered flags
//   busy            - multi-cycle operation in progress
//   done            - one-cycle pulse when y and the flags update
module alu_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] y,
   output logic             c_out,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = SHW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             dir_q, dir_d;          // 1 = shift left
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic [SHW-1:0]   sh_amt;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sh_nxt;
   logic             sh_out;
   logic [PW-1:0]    prod_nxt;

   assign sh_amt = b[SHW-1:0];

   // State register and all datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         dir_q    <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         y_q      <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         dir_q    <= dir_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         y_q      <= y_d;
         c_q      <= c_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if ((op_code == 4'b1001 || op_code == 4'b1010) && sh_amt != '0)
                     state_d = SHIFT;
                  else if (op_code == 4'b1011)
                     state_d = MUL;
               end
            end
            SHIFT, MUL: if (cnt_q == CW'(1)) state_d = IDLE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      dir_d    = dir_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      y_d      = y_q;
      c_d      = c_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      done_d   = 1'b0;
      busy_d   = (state_d != IDLE);

      // Second adder operand; accumulate uses the current result
      case (op_code)
         4'b0001: opb = b;
         4'b0010: opb = ~b;
         4'b0011: opb = '1;
         4'b1100: opb = y_q;
         default: opb = '0;
      endcase
      sum = {1'b0, a} + {1'b0, opb} + (WIDTH + 1)'(c_in);

      sh_out   = dir_q ? sh_q[WIDTH-1] : sh_q[0];
      sh_nxt   = dir_q ? (sh_q << 1) : (sh_q >> 1);
      prod_nxt = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  done_d = 1'b1;
                  case (op_code)
                     4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1100: begin
                        y_d = sum[WIDTH-1:0];
                        c_d = sum[WIDTH];
                        v_d = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                     end
                     4'b0100: begin y_d = a & b; c_d = 1'b0; v_d = 1'b0; end
                     4'b0101: begin y_d = a | b; c_d = 1'b0; v_d = 1'b0; end
                     4'b0110: begin y_d = a ^ b; c_d = 1'b0; v_d = 1'b0; end
                     4'b0111: begin y_d = ~a;    c_d = 1'b0; v_d = 1'b0; end
                     4'b1001, 4'b1010: begin
                        dir_d = (op_code == 4'b1001);
                        sh_d  = a;
                        cnt_d = CW'(sh_amt);
                        if (sh_amt == '0) begin
                           y_d = a;
                           c_d = 1'b0;
                           v_d = 1'b0;
                        end else begin
                           done_d = 1'b0;
                        end
                     end
                     4'b1011: begin
                        mcand_d  = PW'(a);
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = CW'(WIDTH);
                        done_d   = 1'b0;
                     end
                     default: begin y_d = '0; c_d = 1'b0; v_d = 1'b0; end
                  endcase
               end
            end
            SHIFT: begin
               sh_d  = sh_nxt;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  y_d    = sh_nxt;
                  c_d    = sh_out;
                  v_d    = 1'b0;
                  done_d = 1'b1;
               end
            end
            MUL: begin
               prod_d   = prod_nxt;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  y_d    = prod_nxt[WIDTH-1:0];
                  c_d    = |prod_nxt[PW-1:WIDTH];
                  v_d    = |prod_nxt[PW-1:WIDTH];
                  done_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // zero/negative follow the newly written result
      if (done_d) begin
         z_d = (y_d == '0);
         n_d = y_d[WIDTH-1];
      end
   end

   assign y        = y_q;
   assign c_out    = c_q;
   assign zero     = z_q;
   assign negative = n_q;
   assign overflow = v_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); inputs driven and outputs sampled
// on the falling edge.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst, en, start, c_in;
   logic [3:0] op_code;
   logic [7:0] a, b, y;
   logic       c_out, zero, negative, overflow, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .op_code(op_code),
      .a(a), .b(b), .c_in(c_in), .y(y), .c_out(c_out), .zero(zero),
      .negative(negative), .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request for one edge; returns at the sample point after acceptance
   task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        input logic ci);
      op_code = op; a = aa; b = bb; c_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Cycles after acceptance until done, bounded
   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   function automatic logic [3:0] flags();
      return {c_out, zero, negative, overflow};
   endfunction

   initial begin
      int lat;
      int k;

      // Reset with start held high
      rst = 1'b1; en = 1'b1; start = 1'b1; op_code = 4'b0001;
      a = 8'hFF; b = 8'h01; c_in = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_y", 32'(y), 32'h00);
      check("rst_flags", 32'(flags()), 32'h0);
      check("rst_busy_done", 32'({busy, done}), 32'h0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      // Add with signed overflow
      issue(4'b0001, 8'h7F, 8'h00, 1'b1);
      check("add_y", 32'(y), 32'h80);
      check("add_flags", 32'(flags()), 32'b0011);
      check("add_done", 32'(done), 32'd1);
      @(negedge clk);
      check("add_done_pulse", 32'(done), 32'd0);

      // Subtract to zero
      issue(4'b0010, 8'h05, 8'h05, 1'b1);
      check("sub_y", 32'(y), 32'h00);
      check("sub_flags", 32'(flags()), 32'b1100);

      // Multiply 13*11 with an ignored start while busy
      issue(4'b1011, 8'd13, 8'd11, 1'b0);
      check("mul_busy0", 32'({busy, done}), 32'b10);
      for (int i = 1; i <= 7; i++) begin
         if (i == 2) begin
            op_code = 4'b0001; a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
         end
         @(negedge clk);
         if (i == 2) start = 1'b0;
         check("mul_busy", 32'({busy, done}), 32'b10);
         check("mul_y_hold", 32'(y), 32'h00);
      end
      @(negedge clk);
      check("mul_done", 32'({busy, done}), 32'b01);
      check("mul_y", 32'(y), 32'h8F);
      check("mul_flags", 32'(flags()), 32'b0010);
      repeat (2) begin
         @(negedge clk);
         check("mul_no_requeue", 32'({busy, done}), 32'b00);
         check("mul_y_kept", 32'(y), 32'h8F);
      end

      // Multiply with two enable-low cycles mid-operation
      issue(4'b1011, 8'd7, 8'd9, 1'b0);
      k = 0;
      while (!done && k < 30) begin
         if (k == 3) en = 1'b0;
         if (k == 5) en = 1'b1;
         @(negedge clk);
         k++;
      end
      en = 1'b1;
      check("mul_en_latency", 32'(k), 32'd10);
      check("mul_en_y", 32'(y), 32'h3F);

      // Multiply with high half nonzero
      issue(4'b1011, 8'hFF, 8'h02, 1'b0);
      wait_done("mulov_done", lat);
      check("mulov_lat", 32'(lat), 32'd8);
      check("mulov_y", 32'(y), 32'hFE);
      check("mulov_flags", 32'(flags()), 32'b1011);

      // Shifts
      issue(4'b1001, 8'h81, 8'h03, 1'b0);
      check("sll_busy", 32'(busy), 32'd1);
      wait_done("sll_done", lat);
      check("sll_lat", 32'(lat), 32'd3);
      check("sll_y", 32'(y), 32'h08);
      check("sll_flags", 32'(flags()), 32'b0000);
      issue(4'b1010, 8'h81, 8'h01, 1'b0);
      wait_done("srl_done", lat);
      check("srl_lat", 32'(lat), 32'd1);
      check("srl_y", 32'(y), 32'h40);
      check("srl_flags", 32'(flags()), 32'b1000);
      issue(4'b1010, 8'h5A, 8'h00, 1'b0);
      check("sh0_done", 32'({busy, done}), 32'b01);
      check("sh0_y", 32'(y), 32'h5A);

      // Logic op
      issue(4'b0111, 8'h0F, 8'h00, 1'b0);
      check("not_y", 32'(y), 32'hF0);
      check("not_flags", 32'(flags()), 32'b0010);

      // Reset during multiply aborts with no done
      issue(4'b1011, 8'd3, 8'd5, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy_done", 32'({busy, done}), 32'b00);
      check("abort_y", 32'(y), 32'h00);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end

      // Accumulate twice
      issue(4'b1100, 8'h10, 8'h00, 1'b0);
      check("acc1_y", 32'(y), 32'h10);
      issue(4'b1100, 8'h10, 8'h00, 1'b0);
      check("acc2_y", 32'(y), 32'h20);
      check("acc2_flags", 32'(flags()), 32'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
